network_tx_interface: RTL and testbench
=======================================

// Module: network_tx_interface
// PURPOSE
//  Host->network transmit side of the NIC. Accepts flits from the host into a TX FIFO.
//  Sends them to the router port with a valid/ready handshake.
//  Store-and-forward: a packet is released only once its tail flit is buffered, so the
//  router never sees a stalled partial packet (except the forced case in BEHAVIOUR).
// PARAMETERS
//  FLIT_WIDTH   32  flit width; bits [FLIT_WIDTH-1 -: 2] = flit type (types::flit_type_t)
//  DEPTH_LOG2   6   FIFO depth = 1<<DEPTH_LOG2 (64 entries)
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  flit_in      in   FLIT_WIDTH  flit from host
//  in_trigger   in   1           host push request
//  nic_ready    out  1           FIFO can accept; push = in_trigger && nic_ready
//  flit_out     out  FLIT_WIDTH  flit to router (FIFO head)
//  valid_out    out  1           flit_out valid
//  out_ready    in   1           router accepts; pop = valid_out && out_ready
//  signal       out  1           1-cycle pulse: tail/single flit popped
//  drop_cnt     out  8           only with NIC_TX_DROP_CNT_EN
// BEHAVIOUR
//  Flit types: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, SINGLE=2'b11. TAIL/SINGLE = "end flit".
//  Reset values:
//   - push/pop index = 0, fifo state EMPTY, tx FSM IDLE, pkt_cnt = 0.
//   - nic_ready = 1, valid_out = 0, signal = 0, drop_cnt = 0.
//   - Reset mid-packet discards all buffered flits.
//  FIFO:
//   - Indices are DEPTH_LOG2 bits and wrap modulo depth.
//   - Occupancy is DEPTH_LOG2+1 bits.
//   - States: EMPTY (occ 0), VACANT (0<occ<depth), FULL (occ=depth).
//   - nic_ready = (state != FULL).
//   - Push and pop in the same cycle: occupancy unchanged; legal in any state that permits each.
//   - Push while FULL is ignored; FIFO contents are unchanged.
//  pkt_cnt:
//   - DEPTH_LOG2+1 bits.
//   - +1 on push of an end flit; -1 on pop of an end flit.
//   - Both in the same cycle: unchanged.
//  tx FSM (registered):
//   - IDLE -> SEND at the edge where next pkt_cnt > 0.
//   - IDLE -> SEND also when FIFO is FULL with pkt_cnt = 0 (forced cut-through: oversize packet).
//   - SEND -> IDLE at the edge popping an end flit when next pkt_cnt = 0 and not forced.
//   - Otherwise stay in the current state.
//  Outputs:
//   - valid_out = (fsm == SEND) && (fifo != EMPTY).
//   - flit_out = mem[pop_index], combinational.
//   - While valid_out && !out_ready, flit_out and valid_out hold stable.
//  Latency:
//   - End flit accepted in cycle N -> valid_out = 1 in cycle N+1 (first flit of the packet).
//   - Then one flit per cycle while out_ready = 1.
//  signal: registered; high in the cycle after an end-flit pop.
// CONFIGURATION
//  NIC_TX_DROP_CNT_EN defined:
//   - drop_cnt increments on every in_trigger while FULL.
//   - Saturates at 8'hFF; cleared only by rst.
//  NIC_TX_DROP_CNT_EN undefined:
//   - drop_cnt port and counter are absent.
//   - Rejected pushes leave no trace.
// STRUCTURE
//  Package types:
//   - flit_type_t enum.
//   - buffer_state_t {EMPTY, VACANT, FULL}.
//   - tx_state_t {IDLE, SEND}.
//   - flit type field position constants.
//  Sub-module flit_fifo:
//   - push/pop/state/occupancy, shared with the RX path.
//   - Packet counter and tx FSM live in this module.
// TESTING
//  1 Push HEAD,BODY,TAIL (0x0000_0001/0x4000_0002/0x8000_0003), out_ready=1
//    -> valid_out rises the cycle after TAIL is accepted; 3 flits out in order.
//    -> signal pulses once, after the TAIL pop.
//  2 Push HEAD,BODY only -> valid_out stays 0 for 20 cycles.
//    Push TAIL -> packet released next cycle.
//  3 SINGLE 0xC000_00AA with out_ready=0 for 5 cycles -> flit_out/valid_out held stable.
//    Raise out_ready -> popped in 1 cycle; FSM back to IDLE.
//  4 Push 64 BODY flits, no tail -> nic_ready=0, forced SEND.
//    64 flits drain; with NIC_TX_DROP_CNT_EN, 3 extra pushes give drop_cnt = 3.
//  5 FIFO holding 2 packets; push and pop every cycle
//    -> occupancy constant, pkt_cnt correct, index wrap past 63 is seamless.
//  6 Assert rst mid-packet (2 of 4 flits sent)
//    -> next cycle valid_out=0, nic_ready=1, signal=0, all counters zero.

Source files
------------

// File: rtl/network_tx_interface_pkg.sv
// -----------------------------------------------------------------------------
// network_tx_interface_pkg
// Shared types for the NIC transmit path: flit type encoding, FIFO fill state,
// transmit FSM states and the location of the flit type field.
// Types are shared by network_tx_interface and network_tx_interface_flit_fifo.
// -----------------------------------------------------------------------------
package network_tx_interface_pkg;

  // Flit type carried in the two most significant bits of every flit.
  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    VACANT = 2'b01,
    FULL   = 2'b10
  } buffer_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // The type field occupies [FLIT_WIDTH-1 -: FLIT_TYPE_W].
  localparam int FLIT_TYPE_W = 2;

  // TAIL and SINGLE both close a packet; they share the set MSB.
  function automatic logic is_end_flit(input logic [FLIT_TYPE_W-1:0] ftype);
    return ftype[FLIT_TYPE_W-1];
  endfunction

endpackage

// File: rtl/network_tx_interface_flit_fifo.sv
// -----------------------------------------------------------------------------
// network_tx_interface_flit_fifo
// Circular flit buffer with EMPTY/VACANT/FULL state tracking. Pushes while FULL
// and pops while EMPTY are ignored; a simultaneous push and pop keeps the
// occupancy unchanged. Head of the buffer is presented combinationally.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (drops all buffered flits)
//   push  in   write din at the push index
//   pop   in   advance the pop index
//   din   in   WIDTH  flit to store
//   dout  out  WIDTH  flit at the pop index
//   state out  buffer_state_t fill state (registered)
// -----------------------------------------------------------------------------
module network_tx_interface_flit_fifo
  import network_tx_interface_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output buffer_state_t    state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] IDX_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2:0]   OCC_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   OCC_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   OCC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] push_idx_r;
  logic [DEPTH_LOG2-1:0] pop_idx_r;
  logic [DEPTH_LOG2:0]   occ_r;
  logic [DEPTH_LOG2:0]   occ_next_s;
  buffer_state_t         state_r;
  buffer_state_t         state_next_s;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign push_ok_s = push && (state_r != FULL);
  assign pop_ok_s  = pop && (state_r != EMPTY);
  assign dout      = mem_r[pop_idx_r];
  assign state     = state_r;

  // Next occupancy and the fill state it implies.
  always_comb begin
    occ_next_s   = occ_r;
    state_next_s = state_r;
    if (push_ok_s && !pop_ok_s) begin
      occ_next_s = occ_r + OCC_ONE;
    end else if (!push_ok_s && pop_ok_s) begin
      occ_next_s = occ_r - OCC_ONE;
    end else begin
      occ_next_s = occ_r;
    end
    if (occ_next_s == OCC_ZERO) begin
      state_next_s = EMPTY;
    end else if (occ_next_s == OCC_FULL) begin
      state_next_s = FULL;
    end else begin
      state_next_s = VACANT;
    end
  end

  // Index, occupancy and state registers; indices wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_idx_r <= IDX_ZERO;
      pop_idx_r  <= IDX_ZERO;
      occ_r      <= OCC_ZERO;
      state_r    <= EMPTY;
    end else begin
      if (push_ok_s) push_idx_r <= push_idx_r + IDX_ONE;
      if (pop_ok_s)  pop_idx_r  <= pop_idx_r + IDX_ONE;
      occ_r   <= occ_next_s;
      state_r <= state_next_s;
    end
  end

  // Flit storage; contents need no reset because the indices define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[push_idx_r] <= din;
  end

endmodule

// File: rtl/network_tx_interface.sv
// -----------------------------------------------------------------------------
// network_tx_interface
// Host->network transmit side of the NIC. Host flits are buffered in a TX FIFO
// and forwarded store-and-forward: a packet is released to the router only once
// its end flit (TAIL/SINGLE) is buffered. If the FIFO fills with no complete
// packet inside, transmission is forced (cut-through) so an oversize packet
// cannot deadlock the buffer.
// Optional feature macro: NIC_TX_DROP_CNT_EN adds drop_cnt, a saturating count
// of host push requests rejected because the FIFO was full.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   flit_in    in   FLIT_WIDTH flit from host
//   in_trigger in   host push request (push = in_trigger && nic_ready)
//   nic_ready  out  FIFO can accept a flit
//   flit_out   out  FLIT_WIDTH FIFO head to router
//   valid_out  out  flit_out valid
//   out_ready  in   router accepts (pop = valid_out && out_ready)
//   signal     out  one-cycle pulse after an end flit is popped
//   drop_cnt   out  8-bit rejected push counter (NIC_TX_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module network_tx_interface
  import network_tx_interface_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  in_trigger,
  output logic                  nic_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic                  signal
`ifdef NIC_TX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};

  buffer_state_t       fifo_state_s;
  tx_state_t           tx_state_r;
  logic [DEPTH_LOG2:0] pkt_cnt_r;
  logic [DEPTH_LOG2:0] pkt_cnt_next_s;
  logic                push_s;
  logic                pop_s;
  logic                push_end_s;
  logic                pop_end_s;
  logic                forced_s;

  network_tx_interface_flit_fifo #(
    .WIDTH      (FLIT_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (flit_in),
    .dout  (flit_out),
    .state (fifo_state_s)
  );

  assign nic_ready  = (fifo_state_s != FULL);
  assign valid_out  = (tx_state_r == SEND) && (fifo_state_s != EMPTY);
  assign push_s     = in_trigger && nic_ready;
  assign pop_s      = valid_out && out_ready;
  assign push_end_s = push_s && is_end_flit(flit_in[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
  assign pop_end_s  = pop_s && is_end_flit(flit_out[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
  // Full buffer holding no complete packet: must start sending or deadlock.
  assign forced_s   = (fifo_state_s == FULL) && (pkt_cnt_r == CNT_ZERO);

  // Number of complete packets buffered after this edge.
  always_comb begin
    pkt_cnt_next_s = pkt_cnt_r;
    case ({push_end_s, pop_end_s})
      2'b10:   pkt_cnt_next_s = pkt_cnt_r + CNT_ONE;
      2'b01:   pkt_cnt_next_s = pkt_cnt_r - CNT_ONE;
      default: pkt_cnt_next_s = pkt_cnt_r;
    endcase
  end

  // Transmit FSM with packet counter and end-of-packet pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= IDLE;
      pkt_cnt_r  <= CNT_ZERO;
      signal     <= 1'b0;
    end else begin
      pkt_cnt_r <= pkt_cnt_next_s;
      signal    <= pop_end_s;
      case (tx_state_r)
        IDLE: begin
          if ((pkt_cnt_next_s != CNT_ZERO) || forced_s) tx_state_r <= SEND;
          else                                           tx_state_r <= IDLE;
        end
        SEND: begin
          // Stay in SEND through a forced drain until a closing end flit leaves.
          if (pop_end_s && (pkt_cnt_next_s == CNT_ZERO) && !forced_s) tx_state_r <= IDLE;
          else                                                         tx_state_r <= SEND;
        end
        default: tx_state_r <= IDLE;
      endcase
    end
  end

`ifdef NIC_TX_DROP_CNT_EN
  // Saturating count of push requests refused while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'h00;
    end else if (in_trigger && !nic_ready && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_network_tx_interface.sv
// -----------------------------------------------------------------------------
// tb_network_tx_interface
// Drives network_tx_interface with directed packet scenarios and a randomized
// phase. A reference model keeps the buffered flits in a queue and derives the
// expected outputs from the packet-release rules: a flit is offered when the
// buffer holds an end flit, or while an oversize-packet drain is in progress.
// -----------------------------------------------------------------------------
module tb_network_tx_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flit_in;
  logic        in_trigger;
  logic        nic_ready;
  logic [31:0] flit_out;
  logic        valid_out;
  logic        out_ready;
  logic        signal;
`ifdef NIC_TX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  network_tx_interface #(.FLIT_WIDTH(32), .DEPTH_LOG2(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flit_in    (flit_in),
    .in_trigger (in_trigger),
    .nic_ready  (nic_ready),
    .flit_out   (flit_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready),
    .signal     (signal)
`ifdef NIC_TX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int n_pops = 0;
  int n_sigs = 0;

  logic [31:0] ref_q[$];
  bit          cut_mode = 1'b0;
  bit          exp_sig  = 1'b0;
  bit          armed    = 1'b0;
  int          exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit q_has_end();
    foreach (ref_q[i]) if (ref_q[i][31]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  // Reference model: compare outputs mid-cycle, then apply the upcoming edge.
  always @(negedge clk) begin : model
    bit has_end, exp_valid, exp_ready, pop, push, pop_end;
    if (rst) begin
      ref_q.delete();
      cut_mode = 1'b0;
      exp_sig  = 1'b0;
      exp_drop = 0;
      armed    = 1'b1;
    end else if (armed) begin
      has_end   = q_has_end();
      exp_ready = (ref_q.size() < 64);
      exp_valid = (ref_q.size() != 0) && (has_end || cut_mode);
      check("nic_ready", 32'(nic_ready), 32'(exp_ready));
      check("valid_out", 32'(valid_out), 32'(exp_valid));
      check("signal", 32'(signal), 32'(exp_sig));
      if (exp_valid) check("flit_out", flit_out, ref_q[0]);
`ifdef NIC_TX_DROP_CNT_EN
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif
      if (valid_out && out_ready) n_pops++;
      if (signal) n_sigs++;
      pop     = exp_valid && out_ready;
      push    = in_trigger && exp_ready;
      pop_end = pop && ref_q[0][31];
      if (!cut_mode && ref_q.size() == 64 && !has_end) cut_mode = 1'b1;
      if (pop)  void'(ref_q.pop_front());
      if (push) ref_q.push_back(flit_in);
      if (cut_mode && pop_end && !q_has_end()) cut_mode = 1'b0;
      exp_sig = pop_end;
      if (in_trigger && !exp_ready && exp_drop < 255) exp_drop++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one flit and hold it until the FIFO takes it (bounded).
  task automatic push(input logic [31:0] f);
    int  guard;
    bit  ok;
    guard      = 0;
    flit_in    = f;
    in_trigger = 1'b1;
    forever begin
      @(negedge clk);
      ok = nic_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 200) begin
        check("push_timeout", 32'(guard), 32'(0));
        break;
      end
    end
    in_trigger = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int p0, s0;
    rst = 1'b1; flit_in = 32'h0; in_trigger = 1'b0; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: three-flit packet, released after its tail.
    p0 = n_pops; s0 = n_sigs;
    out_ready = 1'b1;
    push(32'h0000_0001); push(32'h4000_0002); push(32'h8000_0003);
    tick(6);
    check("t1_pops", 32'(n_pops - p0), 32'd3);
    check("t1_signal", 32'(n_sigs - s0), 32'd1);

    // 2: incomplete packet must not be released.
    p0 = n_pops;
    push(32'h0000_0011); push(32'h4000_0012);
    tick(20);
    check("t2_held", 32'(n_pops - p0), 32'd0);
    push(32'h8000_0013);
    tick(6);
    check("t2_pops", 32'(n_pops - p0), 32'd3);

    // 3: single flit held under backpressure.
    p0 = n_pops; s0 = n_sigs;
    out_ready = 1'b0;
    push(32'hC000_00AA);
    tick(5);
    check("t3_stall", 32'(n_pops - p0), 32'd0);
    out_ready = 1'b1;
    tick(3);
    check("t3_pops", 32'(n_pops - p0), 32'd1);
    check("t3_signal", 32'(n_sigs - s0), 32'd1);

    // 4: oversize packet fills the FIFO and forces cut-through.
    p0 = n_pops; s0 = n_sigs;
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) push(mk(2'b01, 30'(i + 256)));
    check("t4_full", 32'(nic_ready), 32'd0);
    flit_in = mk(2'b01, 30'h3FF); in_trigger = 1'b1;
    tick(3);
    in_trigger = 1'b0;
`ifdef NIC_TX_DROP_CNT_EN
    check("t4_drop_cnt", 32'(drop_cnt), 32'd3);
`endif
    out_ready = 1'b1;
    tick(70);
    check("t4_pops", 32'(n_pops - p0), 32'd64);
    check("t4_signal", 32'(n_sigs - s0), 32'd0);
    push(mk(2'b10, 30'h3FE));
    tick(4);
    check("t4_tail", 32'(n_pops - p0), 32'd65);

    // 5: two packets buffered, then push and pop every cycle across the wrap.
    p0 = n_pops; s0 = n_sigs;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(mk(2'((i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 2), 30'(i + 512)));
    out_ready = 1'b1;
    for (int i = 0; i < 150; i++) push(mk(2'((i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 2), 30'($urandom)));
    tick(10);
    check("t5_pops", 32'(n_pops - p0), 32'd156);
    check("t5_signal", 32'(n_sigs - s0), 32'd52);

    // Randomized traffic with arbitrary flit types.
    for (int i = 0; i < 1500; i++) begin
      in_trigger = 1'($urandom_range(0, 1));
      flit_in    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      tick(1);
    end
    in_trigger = 1'b0; out_ready = 1'b1;
    tick(100);

    // 6: reset with half a packet sent.
    rst = 1'b1; tick(1); rst = 1'b0;
    out_ready = 1'b0;
    push(32'h0000_0A01); push(32'h4000_0A02); push(32'h4000_0A03); push(32'h8000_0A04);
    p0 = n_pops;
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;
    check("t6_sent", 32'(n_pops - p0), 32'd2);
    rst = 1'b1; tick(1); rst = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(valid_out), 32'd0);
    check("t6_ready", 32'(nic_ready), 32'd1);
    check("t6_signal", 32'(signal), 32'd0);
`ifdef NIC_TX_DROP_CNT_EN
    check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick(10);
    check("t6_flushed", 32'(n_pops - p0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
